jk_mod_counter: RTL and testbench



---
 rtl/jk_seq_pkg.sv | 16 +
 rtl/jk_cell.sv | 31 +++
 rtl/jk_mod_counter.sv | 122 ++++++++++++
 tb/tb_jk_mod_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// Shared definitions for JK-based sequential blocks: cell command
// encoding and the minimal JK excitation function.
package jk_seq_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Minimal excitation: drive J only for a 0->1 move, K only for 1->0.
    // A bit that keeps its value gets JK_HOLD, so JK_TGL is never produced.
    function automatic logic [1:0] jk_excite(input logic present_bit, input logic next_bit);
        return {next_bit & ~present_bit, ~next_bit & present_bit};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
module jk_cell
    import jk_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;

    // JK update: hold, clear, set or toggle on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: q_q <= q_q;
                JK_CLR:  q_q <= 1'b0;
                JK_SET:  q_q <= 1'b1;
                JK_TGL:  q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from a bank of JK cells. The top level
// chooses the next state, derives J/K per bit from present/next state,
// and keeps a sticky wrap flag. Out-of-range states recover on the next
// count (up -> 0, down -> MODULUS-1).
module jk_mod_counter
    import jk_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             wrapped
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    // One extra bit so MODULUS == 2**WIDTH is representable in compares.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic             in_range_s;
    logic             din_ok_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             tc_s;
    logic             wrapped_q;

    assign in_range_s = ({1'b0, q_s} < MOD_EXT);
    assign din_ok_s   = ({1'b0, din} < MOD_EXT);
    assign at_max_s   = (q_s == MAX_VAL);
    assign at_zero_s  = (q_s == ZERO);

    // Terminal count: the cycle on which an enabled count will wrap.
    assign tc_s = en & ~load & ((up & at_max_s) | (~up & at_zero_s));

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        next_d = q_s;
        if (load) begin
            if (din_ok_s) begin
                next_d = din;
            end else begin
                next_d = ZERO;
            end
        end else if (en) begin
            if (up) begin
                if (at_max_s || !in_range_s) begin
                    next_d = ZERO;
                end else begin
                    next_d = q_s + ONE;
                end
            end else begin
                if (at_zero_s || !in_range_s) begin
                    next_d = MAX_VAL;
                end else begin
                    next_d = q_s - ONE;
                end
            end
        end else begin
            next_d = q_s;
        end
    end

    // Per-bit J/K excitation from present and next state.
    always_comb begin
        j_s = ZERO;
        k_s = ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            {j_s[i], k_s[i]} = jk_excite(q_s[i], next_d[i]);
        end
    end

    // Outputs are forced quiet while reset is held.
    assign j_vec = reset ? j_s : ZERO;
    assign k_vec = reset ? k_s : ZERO;
    assign tc    = reset & tc_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (reset),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (q_s[i])
        );
    end

    assign q = q_s;

    // Sticky wrap flag: load clears, a terminal-count edge sets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrapped_q <= 1'b0;
        end else if (load) begin
            wrapped_q <= 1'b0;
        end else if (tc_s) begin
            wrapped_q <= 1'b1;
        end else begin
            wrapped_q <= wrapped_q;
        end
    end

    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: a BCD instance (defaults) and a
// power-of-two instance (WIDTH=3, MODULUS=8). Stimulus pushes expected
// outputs; a monitor on the falling edge pops and compares.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_en, a_up, a_load;
    logic [3:0] a_din, a_q, a_j, a_k;
    logic       a_tc, a_wr;
    logic       b_en, b_up, b_load;
    logic [2:0] b_din, b_q, b_j, b_k;
    logic       b_tc, b_wr;

    typedef struct {
        string      name;
        bit         sel;
        logic [3:0] q;
        logic [3:0] j;
        logic [3:0] k;
        logic       tc;
        logic       wr;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    jk_mod_counter dut_a (
        .clk(clk), .reset(reset), .en(a_en), .up(a_up), .load(a_load), .din(a_din),
        .q(a_q), .j_vec(a_j), .k_vec(a_k), .tc(a_tc), .wrapped(a_wr)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clk(clk), .reset(reset), .en(b_en), .up(b_up), .load(b_load), .din(b_din),
        .q(b_q), .j_vec(b_j), .k_vec(b_k), .tc(b_tc), .wrapped(b_wr)
    );

    // Monitor: J and K never both high, then drain pending expectations.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [3:0] aq, aj, ak;
        logic       atc, awr;
        n_chk++;
        if (((a_j & a_k) != 4'd0) || ((b_j & b_k) != 3'd0)) begin
            $display("FAIL jk_disjoint: a j&k=%b b j&k=%b, required 0", a_j & a_k, b_j & b_k);
        end else begin
            n_pass++;
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sel) begin
                aq = {1'b0, b_q}; aj = {1'b0, b_j}; ak = {1'b0, b_k}; atc = b_tc; awr = b_wr;
            end else begin
                aq = a_q; aj = a_j; ak = a_k; atc = a_tc; awr = a_wr;
            end
            n_chk++;
            if (aq !== e.q || aj !== e.j || ak !== e.k || atc !== e.tc || awr !== e.wr) begin
                $display("FAIL %s: got q=%0d j=%b k=%b tc=%b wrapped=%b, required q=%0d j=%b k=%b tc=%b wrapped=%b",
                         e.name, aq, aj, ak, atc, awr, e.q, e.j, e.k, e.tc, e.wr);
            end else begin
                n_pass++;
            end
        end
    end

    // One cycle of stimulus: drive after the edge, push expected outputs.
    // qe is the count after the edge; ne the next state the inputs select.
    task automatic step(input string nm, input bit sel, input logic rst,
                        input logic e, input logic u, input logic l, input logic [3:0] d,
                        input logic [3:0] qe, input logic [3:0] ne,
                        input logic tce, input logic wre);
        exp_t x;
        @(posedge clk);
        #1;
        reset = rst;
        if (sel) begin
            b_en = e; b_up = u; b_load = l; b_din = d[2:0];
        end else begin
            a_en = e; a_up = u; a_load = l; a_din = d;
        end
        x.name = nm; x.sel = sel; x.q = qe;
        x.j = ne & ~qe;
        x.k = ~ne & qe;
        x.tc = tce; x.wr = wre;
        sb_q.push_back(x);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] mq, mn;
        logic       mwr, mtc, re, ru, rl;
        logic [3:0] rd;

        reset = 1'b0;
        a_en = 1'b0; a_up = 1'b0; a_load = 1'b0; a_din = 4'd0;
        b_en = 1'b0; b_up = 1'b0; b_load = 1'b0; b_din = 3'd0;

        // Reset held: outputs gated even with en=1, down, q=0.
        step("rst_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        step("rst_release", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);

        // BCD up count 1..9, wrap to 0, then on to 7.
        for (int i = 1; i <= 8; i++)
            step("bcd_up", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i), 4'(i + 1), 1'b0, 1'b0);
        step("bcd_q9", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 4'd0, 1'b1, 1'b0);
        step("bcd_wrap", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++)
            step("bcd_after", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i), 4'(i + 1), 1'b0, 1'b1);
        step("hold7", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 4'd7, 1'b0, 1'b1);

        // Reset mid-count between edges, then resume.
        step("rst_mid", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        step("rst_mid_rel", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        step("resume", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);

        // Load 0, then down wrap 0 -> 9 -> 8 ...
        step("load0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0);
        step("dn_tc", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
        for (int i = 9; i >= 6; i--)
            step("dn_count", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(i), 4'(i - 1), 1'b0, 1'b1);

        // Load priority over en, illegal value maps to 0, then legal load.
        step("ld_illegal", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 4'd5, 4'd0, 1'b0, 1'b1);
        step("ld_3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 4'd0, 4'd3, 1'b0, 1'b0);
        for (int i = 3; i <= 5; i++)
            step("up_to6", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i), 4'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step("hold6", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd6, 4'd6, 1'b0, 1'b0);

        // Corrupt a cell: 6 -> 14, up count recovers to 0 with tc low.
        @(negedge clk);
        #1;
        force dut_a.g_bit[3].u_cell.q_q = 1'b1;
        #1;
        release dut_a.g_bit[3].u_cell.q_q;
        step("oor_up", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd14, 4'd0, 1'b0, 1'b0);
        step("oor_up_res", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Corrupt to 12, down count recovers to 9 with tc low.
        @(negedge clk);
        #1;
        force dut_a.g_bit[3].u_cell.q_q = 1'b1;
        force dut_a.g_bit[2].u_cell.q_q = 1'b1;
        #1;
        release dut_a.g_bit[3].u_cell.q_q;
        release dut_a.g_bit[2].u_cell.q_q;
        step("oor_dn", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd12, 4'd9, 1'b0, 1'b0);
        step("oor_dn_res", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 4'd9, 1'b0, 1'b0);

        // Random en/up/load run against a small reference model.
        mq = 4'd9;
        mwr = 1'b0;
        for (int c = 0; c < 200; c++) begin
            re = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 7) == 0);
            rd = 4'($urandom_range(0, 15));
            mtc = re & ~rl & ((ru & (mq == 4'd9)) | (~ru & (mq == 4'd0)));
            if (rl)       mn = (rd < 4'd10) ? rd : 4'd0;
            else if (!re) mn = mq;
            else if (ru)  mn = (mq == 4'd9) ? 4'd0 : mq + 4'd1;
            else          mn = (mq == 4'd0) ? 4'd9 : mq - 4'd1;
            step("rand", 1'b0, 1'b1, re, ru, rl, rd, mq, mn, mtc, mwr);
            if (rl)       mwr = 1'b0;
            else if (mtc) mwr = 1'b1;
            mq = mn;
        end
        @(negedge clk);
        #1;
        a_en = 1'b0; a_load = 1'b0;

        // Power-of-two instance: natural overflow in both directions.
        step("b_ld7", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd0, 4'd7, 1'b0, 1'b0);
        step("b_up_tc", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd7, 4'd0, 1'b1, 1'b0);
        step("b_dn_tc", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1);
        step("b_dn_wr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 4'd7, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
